// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I core: sequences fetch/decode/execute/memory/writeback
// over a shared datapath, with a memory ready handshake and a sticky illegal-instruction trap.
module multicycle_controller #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit FULL_BRANCH   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       Neg,
  input  logic       Carry,
  input  logic       Ovf,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic       Illegal,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  state_t state, state_next;
  logic   ready;
  logic   is_r;
  logic   dec_bad;
  logic   br_ok;
  logic   taken;
  logic [3:0] alu_dec;

  assign ready = MEM_HANDSHAKE ? MemReady : 1'b1;
  assign is_r  = (op == 7'b0110011);
  assign State = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_next;
  end

  // funct7b5 is an immediate bit for I-type ops other than the shifts
  always_comb begin
    alu_dec = ALU_ADD;
    dec_bad = 1'b0;
    case (funct3)
      3'b000: alu_dec = (is_r && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001: begin alu_dec = ALU_SLL;  dec_bad = funct7b5;        end
      3'b010: begin alu_dec = ALU_SLT;  dec_bad = is_r & funct7b5; end
      3'b011: begin alu_dec = ALU_SLTU; dec_bad = is_r & funct7b5; end
      3'b100: begin alu_dec = ALU_XOR;  dec_bad = is_r & funct7b5; end
      3'b101: alu_dec = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110: begin alu_dec = ALU_OR;   dec_bad = is_r & funct7b5; end
      default: begin alu_dec = ALU_AND; dec_bad = is_r & funct7b5; end
    endcase
  end

  always_comb begin
    br_ok = FULL_BRANCH ? (funct3[2:1] != 2'b01) : (funct3[2:1] == 2'b00);
    case (funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = ~Zero;
      3'b100:  taken = Neg ^ Ovf;
      3'b101:  taken = ~(Neg ^ Ovf);
      3'b110:  taken = ~Carry;
      3'b111:  taken = Carry;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    MemReq     = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ImmSrc     = 2'b00;
    ALUControl = ALU_ADD;
    Illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        MemReq    = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        // Write enables are held off while reset is asserted
        IRWrite   = ready & reset;
        PCWrite   = ready & reset;
        if (ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = 2'b10;
        case (op)
          7'b0000011, 7'b0100011: state_next = S_MEMADR;
          7'b0110011:             state_next = S_EXECR;
          7'b0010011:             state_next = S_EXECI;
          7'b1100011:             state_next = br_ok ? S_BRANCH : S_ILLEGAL;
          7'b1101111:             state_next = S_JAL;
          default:                state_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ImmSrc     = op[5] ? 2'b01 : 2'b00;
        state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
        if (ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        MemReq   = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
        if (ready) state_next = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = (state == S_EXECI) ? 2'b01 : 2'b00;
        ALUControl = alu_dec;
        state_next = dec_bad ? S_ILLEGAL : S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        PCWrite    = 1'b1;
        state_next = S_ALUWB;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        PCWrite    = taken;
        state_next = S_FETCH;
      end
      default: begin
        Illegal    = 1'b1;
        state_next = S_ILLEGAL;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected state and control word are queued
// as each instruction is driven and popped at the falling edge.
module tb_multicycle_controller;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero, Neg, Carry, Ovf, MemReady;

  logic       a_MemReq, a_MemWrite, a_AdrSrc, a_IRWrite, a_PCWrite, a_RegWrite, a_Illegal;
  logic [1:0] a_ResultSrc, a_ALUSrcA, a_ALUSrcB, a_ImmSrc;
  logic [3:0] a_ALUControl, a_State;
  logic       b_MemReq, b_MemWrite, b_AdrSrc, b_IRWrite, b_PCWrite, b_RegWrite, b_Illegal;
  logic [1:0] b_ResultSrc, b_ALUSrcA, b_ALUSrcB, b_ImmSrc;
  logic [3:0] b_ALUControl, b_State;
  logic       c_MemReq, c_MemWrite, c_AdrSrc, c_IRWrite, c_PCWrite, c_RegWrite, c_Illegal;
  logic [1:0] c_ResultSrc, c_ALUSrcA, c_ALUSrcB, c_ImmSrc;
  logic [3:0] c_ALUControl, c_State;

  multicycle_controller #(.MEM_HANDSHAKE(1'b1), .FULL_BRANCH(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .Neg(Neg), .Carry(Carry), .Ovf(Ovf), .MemReady(MemReady),
    .MemReq(a_MemReq), .MemWrite(a_MemWrite), .AdrSrc(a_AdrSrc), .IRWrite(a_IRWrite),
    .PCWrite(a_PCWrite), .RegWrite(a_RegWrite), .ResultSrc(a_ResultSrc), .ALUSrcA(a_ALUSrcA),
    .ALUSrcB(a_ALUSrcB), .ImmSrc(a_ImmSrc), .ALUControl(a_ALUControl), .Illegal(a_Illegal),
    .State(a_State));

  multicycle_controller #(.MEM_HANDSHAKE(1'b1), .FULL_BRANCH(1'b0)) dut_fb0 (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .Neg(Neg), .Carry(Carry), .Ovf(Ovf), .MemReady(MemReady),
    .MemReq(b_MemReq), .MemWrite(b_MemWrite), .AdrSrc(b_AdrSrc), .IRWrite(b_IRWrite),
    .PCWrite(b_PCWrite), .RegWrite(b_RegWrite), .ResultSrc(b_ResultSrc), .ALUSrcA(b_ALUSrcA),
    .ALUSrcB(b_ALUSrcB), .ImmSrc(b_ImmSrc), .ALUControl(b_ALUControl), .Illegal(b_Illegal),
    .State(b_State));

  multicycle_controller #(.MEM_HANDSHAKE(1'b0), .FULL_BRANCH(1'b1)) dut_nohs (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .Neg(Neg), .Carry(Carry), .Ovf(Ovf), .MemReady(1'b0),
    .MemReq(c_MemReq), .MemWrite(c_MemWrite), .AdrSrc(c_AdrSrc), .IRWrite(c_IRWrite),
    .PCWrite(c_PCWrite), .RegWrite(c_RegWrite), .ResultSrc(c_ResultSrc), .ALUSrcA(c_ALUSrcA),
    .ALUSrcB(c_ALUSrcB), .ImmSrc(c_ImmSrc), .ALUControl(c_ALUControl), .Illegal(c_Illegal),
    .State(c_State));

  logic [18:0] a_word;
  assign a_word = {a_MemReq, a_MemWrite, a_AdrSrc, a_IRWrite, a_PCWrite, a_RegWrite,
                   a_ResultSrc, a_ALUSrcA, a_ALUSrcB, a_ImmSrc, a_ALUControl, a_Illegal};

  typedef struct {
    string       tag;
    logic [3:0]  st;
    logic [18:0] w;
    logic [18:0] m;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [18:0] mk(input logic mreq, input logic mwr, input logic adr,
                                     input logic irw, input logic pcw, input logic rw,
                                     input logic [1:0] rs, input logic [1:0] sa,
                                     input logic [1:0] sbs, input logic [1:0] imm,
                                     input logic [3:0] alu, input logic ill);
    return {mreq, mwr, adr, irw, pcw, rw, rs, sa, sbs, imm, alu, ill};
  endfunction

  localparam logic [18:0] ALL = 19'h7FFFF;

  function automatic logic [18:0] w_fetch(input logic rdy);
    return mk(1'b1, 1'b0, 1'b0, rdy, rdy, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 4'd0, 1'b0);
  endfunction
  function automatic logic [18:0] w_dec();
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b10, 4'd0, 1'b0);
  endfunction
  function automatic logic [18:0] w_memadr(input logic [1:0] imm);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, imm, 4'd0, 1'b0);
  endfunction
  function automatic logic [18:0] w_exec(input logic imm_b, input logic [3:0] alu);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, {1'b0, imm_b}, 2'b00, alu, 1'b0);
  endfunction
  function automatic logic [18:0] w_br(input logic t);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, t, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 4'b0001, 1'b0);
  endfunction

  localparam logic [18:0] W_MEMRD = 19'b1_0_1_0_0_0_00_00_00_00_0000_0;
  localparam logic [18:0] W_MEMWB = 19'b0_0_0_0_0_1_01_00_00_00_0000_0;
  localparam logic [18:0] W_MEMWR = 19'b1_1_1_0_0_0_00_00_00_00_0000_0;
  localparam logic [18:0] W_ALUWB = 19'b0_0_0_0_0_1_00_00_00_00_0000_0;
  localparam logic [18:0] W_JAL   = 19'b0_0_0_0_1_0_00_01_10_00_0000_0;
  localparam logic [18:0] W_ILL   = 19'b0_0_0_0_0_0_00_00_00_00_0000_1;

  task automatic push(input string tag, input logic [3:0] st, input logic [18:0] w,
                      input logic [18:0] m);
    exp_t e;
    e.tag = tag; e.st = st; e.w = w; e.m = m;
    sb.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    @(negedge clk);
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_state"}, {28'd0, a_State}, {28'd0, e.st});
      chk({e.tag, "_ctrl"}, {13'd0, a_word & e.m}, {13'd0, e.w & e.m});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ins(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op = o; funct3 = f3; funct7b5 = f7;
  endtask

  task automatic fetch_decode(input string tag);
    MemReady = 1'b1;
    push({tag, "_fetch"}, 4'd0, w_fetch(1'b1), ALL); step();
    push({tag, "_decode"}, 4'd1, w_dec(), ALL);      step();
  endtask

  initial begin
    reset = 1'b0; MemReady = 1'b1;
    Zero = 1'b0; Neg = 1'b0; Carry = 1'b0; Ovf = 1'b0;
    set_ins(7'b0110011, 3'b000, 1'b0);

    // Reset: FETCH outputs with write enables held low even though MemReady=1
    push("rst", 4'd0, w_fetch(1'b0), ALL); step();
    reset = 1'b1;

    set_ins(7'b0110011, 3'b000, 1'b0); fetch_decode("add");
    push("add_execr", 4'd6, w_exec(1'b0, 4'b0000), ALL); step();
    push("add_aluwb", 4'd8, W_ALUWB, ALL);               step();

    set_ins(7'b0110011, 3'b000, 1'b1); fetch_decode("sub");
    push("sub_execr", 4'd6, w_exec(1'b0, 4'b0001), ALL); step();
    push("sub_aluwb", 4'd8, W_ALUWB, ALL);               step();

    set_ins(7'b0110011, 3'b011, 1'b0); fetch_decode("sltu");
    push("sltu_execr", 4'd6, w_exec(1'b0, 4'b0110), ALL); step();
    push("sltu_aluwb", 4'd8, W_ALUWB, ALL);                step();

    set_ins(7'b0000011, 3'b010, 1'b0); fetch_decode("lw");
    push("lw_memadr", 4'd2, w_memadr(2'b00), ALL); step();
    MemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push("lw_memread_wait", 4'd3, W_MEMRD, ALL); step();
    end
    MemReady = 1'b1;
    push("lw_memread", 4'd3, W_MEMRD, ALL); step();
    push("lw_memwb", 4'd4, W_MEMWB, ALL);   step();

    set_ins(7'b0100011, 3'b010, 1'b0);
    MemReady = 1'b0;
    push("sw_fetch_wait", 4'd0, w_fetch(1'b0), ALL); step();
    fetch_decode("sw");
    push("sw_memadr", 4'd2, w_memadr(2'b01), ALL); step();
    MemReady = 1'b0;
    push("sw_memwrite_wait", 4'd5, W_MEMWR, ALL); step();
    MemReady = 1'b1;
    push("sw_memwrite", 4'd5, W_MEMWR, ALL); step();

    set_ins(7'b1100011, 3'b100, 1'b0); Neg = 1'b1; Ovf = 1'b0;
    fetch_decode("blt_t");
    push("blt_t_branch", 4'd10, w_br(1'b1), ALL); step();
    Ovf = 1'b1;
    fetch_decode("blt_nt");
    push("blt_nt_branch", 4'd10, w_br(1'b0), ALL); step();
    set_ins(7'b1100011, 3'b111, 1'b0); Carry = 1'b1; Neg = 1'b0; Ovf = 1'b0;
    fetch_decode("bgeu_t");
    push("bgeu_t_branch", 4'd10, w_br(1'b1), ALL); step();
    set_ins(7'b1100011, 3'b001, 1'b0); Zero = 1'b1;
    fetch_decode("bne_nt");
    push("bne_nt_branch", 4'd10, w_br(1'b0), ALL); step();
    Zero = 1'b0;

    set_ins(7'b1101111, 3'b000, 1'b0); fetch_decode("jal");
    push("jal_jal", 4'd9, W_JAL, ALL);     step();
    push("jal_aluwb", 4'd8, W_ALUWB, ALL); step();

    set_ins(7'b0010011, 3'b101, 1'b1); fetch_decode("srai");
    push("srai_execi", 4'd7, w_exec(1'b1, 4'b1001), ALL); step();
    push("srai_aluwb", 4'd8, W_ALUWB, ALL);               step();

    set_ins(7'b0010011, 3'b001, 1'b1); fetch_decode("slli_bad");
    push("slli_bad_execi", 4'd7, w_exec(1'b1, 4'b0000), ALL & ~19'h0001E); step();
    for (int i = 0; i < 3; i++) begin
      push("slli_bad_trap", 4'd11, W_ILL, ALL); step();
    end

    reset = 1'b0;
    push("rst_from_trap", 4'd0, w_fetch(1'b0), ALL); step();
    reset = 1'b1;

    // Reset landing in the middle of a store wait
    set_ins(7'b0100011, 3'b010, 1'b0); fetch_decode("swr");
    push("swr_memadr", 4'd2, w_memadr(2'b01), ALL); step();
    MemReady = 1'b0;
    push("swr_memwrite", 4'd5, W_MEMWR, ALL); step();
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mid_memwrite", {31'd0, a_MemWrite}, 32'd0);
    chk("rst_mid_state", {28'd0, a_State}, 32'd0);
    tick();
    reset = 1'b1;
    push("rst_release", 4'd0, w_fetch(1'b0), ALL); step();

    // FULL_BRANCH=0 instance: bltu is illegal and the trap is sticky
    MemReady = 1'b1;
    set_ins(7'b1100011, 3'b110, 1'b0);
    @(negedge clk); chk("fb0_fetch", {28'd0, b_State}, 32'd0);  tick();
    @(negedge clk); chk("fb0_decode", {28'd0, b_State}, 32'd1); tick();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("fb0_trap", {24'd0, b_State, b_Illegal, b_MemReq, b_RegWrite, b_PCWrite},
          {24'd0, 4'd11, 1'b1, 1'b0, 1'b0, 1'b0});
      tick();
    end
    reset = 1'b0;
    @(negedge clk); chk("fb0_rst_clear", {31'd0, b_Illegal}, 32'd0); tick();
    reset = 1'b1;

    // MEM_HANDSHAKE=0 instance has MemReady tied low yet fetch takes one cycle
    set_ins(7'b0110011, 3'b000, 1'b0);
    MemReady = 1'b0;
    reset = 1'b0;
    @(negedge clk); chk("nohs_rst_irwrite", {31'd0, c_IRWrite}, 32'd0); tick();
    reset = 1'b1;
    @(negedge clk);
    chk("nohs_fetch", {26'd0, c_State, c_IRWrite, c_PCWrite}, {26'd0, 4'd0, 1'b1, 1'b1});
    tick();
    @(negedge clk); chk("nohs_decode", {28'd0, c_State}, 32'd1); tick();

    chk("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
